// File: rtl/uart_frame_receiver.sv
// UART receiver: oversampled start detection, LSB-first data, optional parity, stop check.
// Define UART_RX_MAJORITY_VOTE_EN for a 3-sample majority decision per bit.
module uart_frame_receiver #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    input  logic                      S_DATA,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      DATA_VALID,
    output logic                      PAR_ERR,
    output logic                      STP_ERR
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                    state_reg, state_next;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_reg, edge_cnt_next;
    logic [BW-1:0]             bit_cnt_reg, bit_cnt_next;
    logic [DATA_WIDTH-1:0]     shift_reg, shift_next;
    logic                      par_fail_reg, par_fail_next;
    logic                      armed_reg, armed_next;
    logic                      par_en_reg, par_en_next;
    logic                      par_typ_reg, par_typ_next;
    logic [PRESCALE_WIDTH-1:0] prescale_reg, prescale_next;
    logic                      res_valid_reg, res_valid_next;
    logic                      res_par_reg, res_par_next;
    logic                      res_stp_reg, res_stp_next;

    logic                      rst_meta_reg, rst_sync_reg;
    logic                      sample;
    logic [PRESCALE_WIDTH-1:0] sample_pt;
    logic [PRESCALE_WIDTH-1:0] p_last;
    logic                      at_sample, at_boundary;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rst_meta_reg <= 1'b0;
            rst_sync_reg <= 1'b0;
        end else begin
            rst_meta_reg <= 1'b1;
            rst_sync_reg <= rst_meta_reg;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] hist_reg;

    always_ff @(posedge CLK or negedge rst_sync_reg) begin
        if (!rst_sync_reg) begin
            hist_reg <= 2'b11;
        end else begin
            hist_reg <= {hist_reg[0], S_DATA};
        end
    end

    // hist_reg holds the two previous edges, so the vote completes one edge late.
    assign sample    = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & S_DATA) | (hist_reg[0] & S_DATA);
    assign sample_pt = (prescale_reg >> 1) + 1'b1;
`else
    assign sample    = S_DATA;
    assign sample_pt = prescale_reg >> 1;
`endif

    assign p_last      = prescale_reg - 1'b1;
    assign at_sample   = (edge_cnt_reg == sample_pt);
    assign at_boundary = (edge_cnt_reg == p_last);

    always_ff @(posedge CLK or negedge rst_sync_reg) begin
        if (!rst_sync_reg) begin
            state_reg     <= IDLE;
            edge_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            par_fail_reg  <= 1'b0;
            armed_reg     <= 1'b1;
            par_en_reg    <= 1'b0;
            par_typ_reg   <= 1'b0;
            prescale_reg  <= PRESCALE_WIDTH'(4);
            res_valid_reg <= 1'b0;
            res_par_reg   <= 1'b0;
            res_stp_reg   <= 1'b0;
            P_DATA        <= '0;
            DATA_VALID    <= 1'b0;
            PAR_ERR       <= 1'b0;
            STP_ERR       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            edge_cnt_reg  <= edge_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            par_fail_reg  <= par_fail_next;
            armed_reg     <= armed_next;
            par_en_reg    <= par_en_next;
            par_typ_reg   <= par_typ_next;
            prescale_reg  <= prescale_next;
            res_valid_reg <= res_valid_next;
            res_par_reg   <= res_par_next;
            res_stp_reg   <= res_stp_next;
            DATA_VALID    <= res_valid_reg;
            PAR_ERR       <= res_par_reg;
            STP_ERR       <= res_stp_reg;
            if (res_valid_reg) begin
                P_DATA <= shift_reg;
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        edge_cnt_next  = at_boundary ? '0 : edge_cnt_reg + 1'b1;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        par_fail_next  = par_fail_reg;
        armed_next     = armed_reg;
        par_en_next    = par_en_reg;
        par_typ_next   = par_typ_reg;
        prescale_next  = prescale_reg;
        res_valid_next = 1'b0;
        res_par_next   = 1'b0;
        res_stp_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                edge_cnt_next = '0;
                if (S_DATA) begin
                    armed_next = 1'b1;
                end else if (armed_reg) begin
                    // Start-detect cycle counts as edge 0 of the start bit.
                    state_next    = START;
                    edge_cnt_next = PRESCALE_WIDTH'(1);
                    bit_cnt_next  = '0;
                    par_fail_next = 1'b0;
                    par_en_next   = PAR_EN;
                    par_typ_next  = PAR_TYP;
                    prescale_next = (PRESCALE < PRESCALE_WIDTH'(4)) ? PRESCALE_WIDTH'(4) : PRESCALE;
                end
            end
            START: begin
                if (at_boundary) begin
                    state_next = DATA;
                end
                if (at_sample && sample) begin
                    state_next    = IDLE;
                    edge_cnt_next = '0;
                end
            end
            DATA: begin
                if (at_sample) begin
                    shift_next = {sample, shift_reg[DATA_WIDTH-1:1]};
                end
                if (at_boundary) begin
                    if (bit_cnt_reg == BW'(DATA_WIDTH - 1)) begin
                        bit_cnt_next = '0;
                        state_next   = par_en_reg ? PARITY : STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (at_sample && (sample != (^shift_reg ^ par_typ_reg))) begin
                    par_fail_next = 1'b1;
                end
                if (at_boundary) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leave half a bit early so the next start edge is never missed.
                if (at_sample) begin
                    state_next     = IDLE;
                    edge_cnt_next  = '0;
                    res_valid_next = sample & ~par_fail_reg;
                    res_par_next   = par_fail_reg;
                    res_stp_next   = ~sample;
                    if (!sample) begin
                        armed_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                edge_cnt_next = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_frame_receiver.sv
// Scoreboard bench for uart_frame_receiver: directed cases plus randomized frames
// checked against a frame-level outcome model.
module tb_uart_frame_receiver;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       par_en, par_typ, s_data;
    logic [5:0] prescale;
    logic [7:0] p_data;
    logic       data_valid, par_err, stp_err;

    typedef struct {
        bit         v;
        bit         pe;
        bit         se;
        logic [7:0] d;
        int         start;
        int         lat;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_frames = 0;
    int         cyc = 0;
    int         lat;
    logic [7:0] last_good = 8'h00;

    uart_frame_receiver #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
        .CLK(clk), .RST(rst_n), .PAR_EN(par_en), .PAR_TYP(par_typ),
        .PRESCALE(prescale), .S_DATA(s_data), .P_DATA(p_data),
        .DATA_VALID(data_valid), .PAR_ERR(par_err), .STP_ERR(stp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    // Drives one frame LSB-first and predicts its outcome from the frame contents.
    task automatic send_frame(input logic [7:0] d, input int p_cfg, input bit pe, input bit pt,
                              input bit par_bit, input bit stop_bit, input int gap_bits,
                              input int flip_idx, input int abort_after);
        int   p_eff, nbits, ones;
        bit   par_ok;
        logic bits [0:10];
        exp_t x;
        p_eff = (p_cfg < 4) ? 4 : p_cfg;
        nbits = pe ? 11 : 10;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
        bits[9]  = par_bit;
        bits[nbits - 1] = stop_bit;
        ones   = $countones(d) + (pe ? int'(par_bit) : 0);
        par_ok = !pe || ((ones % 2) == (pt ? 1 : 0));
        par_en   = pe;
        par_typ  = pt;
        prescale = 6'(p_cfg);
        if (abort_after == 0) begin
            x.v  = stop_bit && par_ok;
            x.pe = !par_ok;
            x.se = !stop_bit;
            if (x.v) last_good = d;
            x.d     = last_good;
            x.start = cyc + 1;
            x.lat   = (1 + 8 + int'(pe)) * p_eff + p_eff / 2 + 1;
`ifdef UART_RX_MAJORITY_VOTE_EN
            x.lat   = x.lat + 1;
`endif
            q.push_back(x);
        end
        for (int b = 0; b < nbits; b++) begin
            if (abort_after != 0 && b == abort_after) return;
            for (int k = 0; k < p_eff; k++) begin
                s_data = (b == flip_idx && k == p_eff / 2) ? ~bits[b] : bits[b];
                tick();
                if (b == 0 && k == 0) begin
                    // Config changes mid-frame must not disturb the frame in flight.
                    par_en   = 1'($urandom);
                    par_typ  = 1'($urandom);
                    prescale = 6'($urandom);
                end
            end
        end
        s_data = 1'b1;
        repeat (gap_bits * p_eff) tick();
    endtask

    always @(negedge clk) begin
        if (rst_n && (data_valid || par_err || stp_err)) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: got v=%0b p=%0b s=%0b data=%02h, want no pulse",
                         data_valid, par_err, stp_err, p_data);
            end else begin
                e   = q.pop_front();
                lat = cyc - e.start;
                n_frames++;
                if (data_valid !== e.v || par_err !== e.pe || stp_err !== e.se ||
                    p_data !== e.d || lat != e.lat) begin
                    n_bad++;
                    $display("FAIL frame%0d: got v=%0b p=%0b s=%0b data=%02h lat=%0d, want v=%0b p=%0b s=%0b data=%02h lat=%0d",
                             n_frames, data_valid, par_err, stp_err, p_data, lat,
                             e.v, e.pe, e.se, e.d, e.lat);
                end else begin
                    $display("frame %0d: v=%0b p=%0b s=%0b data=%02h lat=%0d ok",
                             n_frames, data_valid, par_err, stp_err, p_data, lat);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        int         p, gap;
        bit         pe, pt, good, cp, stop;
        rst_n = 1'b0; s_data = 1'b1; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd8;
        repeat (3) tick();
        check("rst_p_data", 32'(p_data), 32'h0);
        check("rst_valid", 32'(data_valid), 32'h0);
        check("rst_par_err", 32'(par_err), 32'h0);
        check("rst_stp_err", 32'(stp_err), 32'h0);
        rst_n = 1'b1;
        repeat (6) tick();

        send_frame(8'hA5, 8, 0, 0, 0, 1, 1, -1, 0);
        send_frame(8'h3C, 16, 1, 0, 0, 1, 1, -1, 0);
        send_frame(8'h3C, 16, 1, 0, 1, 1, 1, -1, 0);
        // Stop bit low, then a held-low line: receiver must wait for idle-high.
        send_frame(8'h81, 8, 0, 0, 0, 0, 0, -1, 0);
        s_data = 1'b0;
        repeat (24) tick();
        s_data = 1'b1;
        repeat (8) tick();
        send_frame(8'h55, 8, 0, 0, 0, 1, 1, -1, 0);
        // Short low glitch on the idle line.
        s_data = 1'b0;
        repeat (2) tick();
        s_data = 1'b1;
        repeat (16) tick();
        send_frame(8'h01, 8, 0, 0, 0, 1, 0, -1, 0);
        send_frame(8'hFE, 8, 0, 0, 0, 1, 1, -1, 0);
        send_frame(8'h96, 3, 0, 0, 0, 1, 1, -1, 0);
`ifdef UART_RX_MAJORITY_VOTE_EN
        send_frame(8'h5A, 8, 0, 0, 0, 1, 1, 3, 0);
`endif

        for (int n = 0; n < 30; n++) begin
            d    = 8'($urandom);
            p    = 5 + int'($urandom_range(11, 0));
            pe   = 1'($urandom);
            pt   = 1'($urandom);
            good = ($urandom % 4) != 0;
            cp   = (($countones(d) % 2) != 0) ^ pt;
            stop = ($urandom % 8) != 0;
            gap  = stop ? int'($urandom_range(2, 0)) : 1 + int'($urandom_range(1, 0));
            send_frame(d, p, pe, pt, good ? cp : ~cp, stop, gap, -1, 0);
        end

        // Back-to-back pair with reset during the second frame.
        send_frame(8'h01, 8, 0, 0, 0, 1, 0, -1, 0);
        send_frame(8'hFE, 8, 0, 0, 0, 1, 0, -1, 4);
        rst_n = 1'b0;
        last_good = 8'h00;
        #1;
        check("abort_p_data", 32'(p_data), 32'h0);
        check("abort_valid", 32'(data_valid), 32'h0);
        repeat (3) tick();
        check("abort_hold_p_data", 32'(p_data), 32'h0);
        check("abort_hold_flags", {29'd0, data_valid, par_err, stp_err}, 32'h0);
        rst_n = 1'b1;
        s_data = 1'b1;
        repeat (20) tick();
        send_frame(8'hC3, 10, 1, 1, 1, 1, 1, -1, 0);

        for (int i = 0; i < 400 && q.size() != 0; i++) tick();
        repeat (4) tick();
        check("scoreboard_drained", 32'(q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
